// File: rtl/l1a_ring_buf_ctrl_pkg.sv
// Shared types for the L1A ring-buffer readout controller.
// Holds the readout FSM state encoding and the drop counter width.
package l1a_rb_pkg;

  typedef enum logic {
    RB_IDLE,
    RB_READ
  } rb_state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/l1a_ring_buf_ctrl_if.sv
// Dual-port block RAM bus between the readout controller and blk_mem.
// master: controller (drives ports A/B, samples ram_dob); slave: RAM.
interface l1a_ring_buf_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 256
);
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dia;
  logic          ram_enb;
  logic          ram_web;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;

  modport master (
    output ram_ena, ram_wea, ram_addra, ram_dia,
    output ram_enb, ram_web, ram_addrb,
    input  ram_dob
  );

  modport slave (
    input  ram_ena, ram_wea, ram_addra, ram_dia,
    input  ram_enb, ram_web, ram_addrb,
    output ram_dob
  );
endinterface

// File: rtl/l1a_ring_buf_ctrl_trig_queue.sv
// Trigger queue: synchronous QD x AW FIFO of window start addresses.
// Ports: push/wdata in, pop in, rdata = head, full/empty status.
module trig_queue #(
  parameter int AW = 10,
  parameter int QD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(QD);

  logic [AW-1:0] mem [QD];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;

  assign full  = (cnt == (PW+1)'(QD));
  assign empty = (cnt == '0);
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      if (push && !pop)
        cnt <= cnt + (PW+1)'(1);
      else if (pop && !push)
        cnt <= cnt - (PW+1)'(1);
    end
  end

  // Head is read combinationally before the edge, so a
  // push+pop on a full queue overwrites the slot just consumed.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/l1a_ring_buf_ctrl.sv
// Circular latency buffer write/readout controller for a dual-port RAM.
// Ports: din/din_valid, l1a, ram bus, dout/valid/first/last, busy, drops.
module l1a_ring_buf_ctrl
  import l1a_rb_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 256,
  parameter int LATENCY = 64,
  parameter int WIN     = 3,
  parameter int QD      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         din,
  input  logic                  din_valid,
  input  logic                  l1a,
  l1a_ring_buf_ctrl_if.master   ram,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  output logic                  dout_first,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  trig_overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int KW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIN - 1);

  if (LATENCY < WIN) begin : g_bad_lat
    $fatal(1, "LATENCY must be >= WIN");
  end
  if (LATENCY + QD * WIN + 2 >= (1 << AW)) begin : g_bad_depth
    $fatal(1, "buffer too shallow for LATENCY/QD/WIN");
  end
  if (QD < 2 || (QD & (QD - 1)) != 0) begin : g_bad_qd
    $fatal(1, "QD must be a power of 2, >= 2");
  end

  rb_state_t     state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] q_start;
  logic [KW-1:0] k;
  logic          q_full;
  logic          q_empty;
  logic          pop;
  logic          push;
  logic          at_last;

  assign at_last = (state == RB_READ) && (k == K_LAST);
  assign pop  = !rst && !q_empty && ((state == RB_IDLE) || at_last);
  assign push = !rst && l1a && (!q_full || pop);

  trig_queue #(
    .AW(AW),
    .QD(QD)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(wr_ptr - AW'(LATENCY)),
    .rdata(q_start),
    .full (q_full),
    .empty(q_empty)
  );

  assign ram.ram_ena   = din_valid;
  assign ram.ram_wea   = din_valid;
  assign ram.ram_addra = wr_ptr;
  assign ram.ram_dia   = din;
  assign ram.ram_enb   = (state == RB_READ);
  assign ram.ram_web   = 1'b0;
  assign ram.ram_addrb = rd_addr;
  assign dout          = ram.ram_dob;
  assign busy          = (state != RB_IDLE) || !q_empty;

  always_ff @(posedge clk) begin
    if (rst)
      wr_ptr <= '0;
    else if (din_valid)
      wr_ptr <= wr_ptr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RB_IDLE;
      rd_addr    <= '0;
      k          <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= (state == RB_READ);
      dout_first <= (state == RB_READ) && (k == '0);
      dout_last  <= at_last;
      unique case (state)
        RB_IDLE: begin
          if (pop) begin
            state   <= RB_READ;
            rd_addr <= q_start;
            k       <= '0;
          end
        end
        RB_READ: begin
          if (at_last && pop) begin
            rd_addr <= q_start;
            k       <= '0;
          end else if (at_last) begin
            state   <= RB_IDLE;
            rd_addr <= rd_addr + AW'(1);
            k       <= '0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
            k       <= k + KW'(1);
          end
        end
        default: state <= RB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_overflow <= 1'b0;
      drop_cnt      <= '0;
    end else if (l1a && !push) begin
      trig_overflow <= 1'b1;
      if (drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_l1a_ring_buf_ctrl.sv
// Self-checking bench for l1a_ring_buf_ctrl with a behavioural RAM and
// a transaction-level trigger/readout model.
module tb_l1a_ring_buf_ctrl;
  import l1a_rb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 256;
  localparam int LATENCY = 64;
  localparam int WIN = 3;
  localparam int QD = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic din_valid;
  logic l1a;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic dout_valid, dout_first, dout_last;
  logic busy, trig_overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  l1a_ring_buf_ctrl_if #(.AW(AW), .DW(DW)) ram ();

  l1a_ring_buf_ctrl #(
    .AW(AW), .DW(DW), .LATENCY(LATENCY), .WIN(WIN), .QD(QD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .l1a          (l1a),
    .ram          (ram),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_first   (dout_first),
    .dout_last    (dout_last),
    .busy         (busy),
    .trig_overflow(trig_overflow),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram.ram_ena && ram.ram_wea) mem[ram.ram_addra] <= ram.ram_dia;
    if (ram.ram_enb) ram.ram_dob <= mem[ram.ram_addrb];
  end

  typedef struct {
    int cyc;
    int addr;
    bit first;
    bit last;
  } ev_t;

  typedef struct {
    int t;
    int s;
  } acc_t;

  ev_t  enb_q[$];
  ev_t  dv_q[$];
  acc_t acc[$];
  logic [DW-1:0] hist [DEPTH];
  int seen_addr[$];
  logic [DW-1:0] seen_dout[$];
  int cyc, mwp, last_s, mdrop, wcnt;
  int n_dv, n_first, n_last;
  bit movf;
  int total, bad;

  // One clock cycle: drive inputs, predict, check at negedge, advance.
  task automatic cycle(input bit dv, input bit l, input bit r);
    int cnt, s, start;
    bit pop_now, exp_busy, ok, exp;
    rst = r;
    din_valid = dv;
    l1a = l;
    din = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, wcnt};
    cnt = 0;
    pop_now = 0;
    exp_busy = 0;
    foreach (acc[i]) begin
      if (acc[i].s >= cyc) cnt++;
      if (acc[i].s == cyc) pop_now = 1;
      if (acc[i].t < cyc && cyc <= acc[i].s + WIN) exp_busy = 1;
    end
    ok = l && !r && (cnt < QD || pop_now);
    start = (mwp - LATENCY + DEPTH) % DEPTH;
    @(negedge clk);
    total++;
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
    end
    total++;
    if (drop_cnt !== 16'(mdrop)) begin
      bad++;
      $display("FAIL drop_cnt cyc=%0d got %0d want %0d", cyc, drop_cnt, mdrop);
    end
    total++;
    if (trig_overflow !== movf) begin
      bad++;
      $display("FAIL ovf cyc=%0d got %b want %b", cyc, trig_overflow, movf);
    end
    total++;
    if ({ram.ram_ena, ram.ram_wea, ram.ram_web} !== {dv, dv, 1'b0}) begin
      bad++;
      $display("FAIL port_a_en cyc=%0d got %b%b%b want %b%b0", cyc,
               ram.ram_ena, ram.ram_wea, ram.ram_web, dv, dv);
    end
    total++;
    if (ram.ram_addra !== AW'(mwp)) begin
      bad++;
      $display("FAIL addra cyc=%0d got %0d want %0d", cyc, ram.ram_addra, mwp);
    end
    exp = enb_q.size() > 0 && enb_q[0].cyc == cyc;
    total++;
    if (ram.ram_enb !== exp) begin
      bad++;
      $display("FAIL enb cyc=%0d got %b want %b", cyc, ram.ram_enb, exp);
    end else if (exp) begin
      total++;
      if (ram.ram_addrb !== AW'(enb_q[0].addr)) begin
        bad++;
        $display("FAIL addrb cyc=%0d got %0d want %0d", cyc,
                 ram.ram_addrb, enb_q[0].addr);
      end
      seen_addr.push_back(int'(ram.ram_addrb));
    end
    while (enb_q.size() > 0 && enb_q[0].cyc <= cyc) void'(enb_q.pop_front());
    exp = dv_q.size() > 0 && dv_q[0].cyc == cyc;
    total++;
    if (dout_valid !== exp) begin
      bad++;
      $display("FAIL dout_valid cyc=%0d got %b want %b", cyc, dout_valid, exp);
    end else if (exp) begin
      n_dv++;
      if (dout_first) n_first++;
      if (dout_last) n_last++;
      seen_dout.push_back(dout);
      total++;
      if (dout !== hist[dv_q[0].addr]) begin
        bad++;
        $display("FAIL dout cyc=%0d got %h want %h", cyc, dout,
                 hist[dv_q[0].addr]);
      end
      total++;
      if ({dout_first, dout_last} !== {dv_q[0].first, dv_q[0].last}) begin
        bad++;
        $display("FAIL first_last cyc=%0d got %b%b want %b%b", cyc,
                 dout_first, dout_last, dv_q[0].first, dv_q[0].last);
      end
    end
    while (dv_q.size() > 0 && dv_q[0].cyc <= cyc) void'(dv_q.pop_front());
    if (dv) hist[mwp] = din;
    if (ok) begin
      s = (cyc + 1 > last_s + WIN) ? cyc + 1 : last_s + WIN;
      acc.push_back('{t: cyc, s: s});
      last_s = s;
      for (int j = 0; j < WIN; j++) begin
        enb_q.push_back('{cyc: s + 1 + j, addr: (start + j) % DEPTH,
                          first: j == 0, last: j == WIN - 1});
        dv_q.push_back('{cyc: s + 2 + j, addr: (start + j) % DEPTH,
                         first: j == 0, last: j == WIN - 1});
      end
    end else if (l && !r) begin
      movf = 1;
      if (mdrop < 65535) mdrop++;
    end
    if (r) begin
      mwp = 0;
      wcnt = 0;
      acc.delete();
      enb_q.delete();
      dv_q.delete();
      last_s = -1000;
      mdrop = 0;
      movf = 0;
    end else if (dv) begin
      mwp = (mwp + 1) % DEPTH;
      wcnt++;
    end
    while (acc.size() > 0 && acc[0].s + WIN < cyc) void'(acc.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0);
  endtask

  task automatic check_addrs(input string name, input int base);
    for (int j = 0; j < WIN; j++) begin
      total++;
      if (j >= seen_addr.size() || seen_addr[j] != (base + j) % DEPTH) begin
        bad++;
        $display("FAIL %s addr[%0d] got %0d want %0d", name, j,
                 (j < seen_addr.size()) ? seen_addr[j] : -1,
                 (base + j) % DEPTH);
      end
    end
  endtask

  task automatic test_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    total++;
    if ({dout_valid, dout_first, dout_last, busy, trig_overflow,
         ram.ram_enb} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got %b%b%b%b%b%b want 000000", dout_valid,
               dout_first, dout_last, busy, trig_overflow, ram.ram_enb);
    end
    total++;
    if (drop_cnt !== '0 || ram.ram_addrb !== '0 || ram.ram_addra !== '0) begin
      bad++;
      $display("FAIL reset_regs got %0d/%0d/%0d want 0/0/0", drop_cnt,
               ram.ram_addrb, ram.ram_addra);
    end
  endtask

  task automatic test_basic();
    seen_addr.delete();
    seen_dout.delete();
    for (int i = 0; i < 100; i++) cycle(1, mwp == 80, 0);
    idle(8);
    check_addrs("basic", 16);
    for (int j = 0; j < WIN; j++) begin
      total++;
      if (j >= seen_dout.size() || seen_dout[j][31:0] !== 32'(16 + j)) begin
        bad++;
        $display("FAIL basic_dout[%0d] got %0d want %0d", j,
                 (j < seen_dout.size()) ? seen_dout[j][31:0] : 32'hffff_ffff,
                 16 + j);
      end
    end
  endtask

  task automatic test_wrap();
    seen_addr.delete();
    cycle(1, 0, 0);
    while (mwp != 10) cycle(1, 0, 0);
    cycle(1, 1, 0);
    idle(8);
    check_addrs("wrap", 970);
  endtask

  task automatic test_back_to_back();
    n_dv = 0;
    n_first = 0;
    n_last = 0;
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    idle(10);
    total++;
    if (n_dv != 6 || n_first != 2 || n_last != 2) begin
      bad++;
      $display("FAIL b2b got dv=%0d first=%0d last=%0d want 6/2/2",
               n_dv, n_first, n_last);
    end
  endtask

  task automatic test_overflow();
    n_dv = 0;
    repeat (8) cycle(0, 1, 0);
    idle(30);
    total++;
    if (drop_cnt !== 16'd1 || trig_overflow !== 1'b1 || n_dv != 21) begin
      bad++;
      $display("FAIL overflow got drops=%0d ovf=%b words=%0d want 1/1/21",
               drop_cnt, trig_overflow, n_dv);
    end
  endtask

  task automatic test_gaps();
    bit t;
    t = 1;
    seen_addr.delete();
    while (mwp != 100) begin
      cycle(t, 0, 0);
      t = !t;
    end
    cycle(t, 1, 0);
    idle(8);
    check_addrs("gaps", 36);
  endtask

  task automatic test_reset_mid();
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    total++;
    if ({dout_valid, busy, ram.ram_enb} !== 3'b000 || ram.ram_addra !== '0) begin
      bad++;
      $display("FAIL reset_mid got dv=%b busy=%b enb=%b addra=%0d want 0/0/0/0",
               dout_valid, busy, ram.ram_enb, ram.ram_addra);
    end
    n_dv = 0;
    seen_addr.delete();
    cycle(1, 1, 0);
    idle(8);
    total++;
    if (n_dv != WIN) begin
      bad++;
      $display("FAIL reset_mid_rearm got %0d words want %0d", n_dv, WIN);
    end
    check_addrs("reset_mid_rearm", DEPTH - LATENCY);
  endtask

  task automatic test_random();
    bit dv, l, r;
    for (int i = 0; i < 3000; i++) begin
      dv = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 499) == 0;
      l = !r && $urandom_range(0, 3) == 0;
      cycle(dv, l, r);
    end
    idle(20);
    total++;
    if (enb_q.size() != 0 || dv_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain got %0d/%0d pending want 0/0",
               enb_q.size(), dv_q.size());
    end
  endtask

  initial begin
    rst = 1;
    din_valid = 0;
    l1a = 0;
    din = '0;
    cyc = 0;
    mwp = 0;
    wcnt = 0;
    last_s = -1000;
    mdrop = 0;
    movf = 0;
    total = 0;
    bad = 0;
    n_dv = 0;
    n_first = 0;
    n_last = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_overflow();
    cycle(0, 0, 1);
    test_gaps();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
